// File: rtl/bpm_hist_ctrl.sv
// bpm_hist_ctrl: sequencing controller for the 4 x 128-bit BPM history RAM.
// Packs 8-bit BPM samples 16 to a line, commits full or flushed lines into
// the RAM as a ring buffer, and serves single-line reads by age (0 = newest).
// Optional build macro BPM_HIST_AVG_EN adds a per-line average output
// (line_avg/avg_valid) computed by a sequential restoring divider.
module bpm_hist_ctrl #(
    parameter int SAMPLE_W = 8,
    parameter int LINE_W   = 128,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bpm_valid,
    input  logic [SAMPLE_W-1:0] bpm_in,
    input  logic                flush,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr_in,
    output logic [LINE_W-1:0]   ram_din,
    output logic [ADDR_W-1:0]   ram_addr_out,
    input  logic [LINE_W-1:0]   ram_dout,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_age,
    output logic                rd_ready,
    output logic                rd_valid,
    output logic                rd_err,
    output logic [LINE_W-1:0]   rd_data,
    output logic [ADDR_W:0]     lines_valid
`ifdef BPM_HIST_AVG_EN
    ,
    output logic [SAMPLE_W-1:0] line_avg,
    output logic                avg_valid
`endif
);

    localparam int SPL   = LINE_W / SAMPLE_W;
    localparam int CNT_W = $clog2(SPL);
    localparam int LV_W  = ADDR_W + 1;

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_CAP} rd_state_e;

    // Fill buffer and commit path
    logic [LINE_W-1:0] fill_q, fill_d, line_w;
    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic              line_done;
    logic              ram_we_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_nxt;
    logic [LINE_W-1:0] ram_din_q;
    logic [LV_W-1:0]   lines_valid_q;

    // Read FSM
    rd_state_e         rd_state_q;
    logic              rd_bad_q;
    logic [ADDR_W-1:0] ram_addr_out_q;
    logic              rd_ready_q, rd_valid_q, rd_err_q;
    logic [LINE_W-1:0] rd_data_q;
    logic              hit_now, hit_next;

    // Merge any same-cycle sample into the line and decide whether it closes.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        line_w = fill_q;
        if (bpm_valid) begin
            line_w[int'(fill_cnt_q)*SAMPLE_W +: SAMPLE_W] = bpm_in;
        end
        line_done  = (bpm_valid && (fill_cnt_q == CNT_W'(SPL-1))) ||
                     (flush && (bpm_valid || (fill_cnt_q != '0)));
        fill_d     = line_w;
        fill_cnt_d = fill_cnt_q + CNT_W'(bpm_valid);
        if (line_done) begin
            fill_d     = '0;
            fill_cnt_d = '0;
        end
    end

    // Write pointer as it will be after this cycle's commit (if any).
    assign wr_ptr_nxt = ram_we_q ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;

    // A commit lands on the latched read address in this cycle or the next.
    assign hit_now  = ram_we_q  && (wr_ptr_q   == ram_addr_out_q);
    assign hit_next = line_done && (wr_ptr_nxt == ram_addr_out_q);

    // Packing, commit strobe and ring-buffer bookkeeping.
    // NOTE: sequential state uses <= only, so every reader sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q        <= '0;
            fill_cnt_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_din_q     <= '0;
            wr_ptr_q      <= '0;
            lines_valid_q <= '0;
        end else begin
            fill_q     <= fill_d;
            fill_cnt_q <= fill_cnt_d;
            ram_we_q   <= line_done;
            if (line_done) begin
                ram_din_q <= line_w;
            end
            if (ram_we_q) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                if (lines_valid_q != LV_W'(DEPTH)) begin
                    lines_valid_q <= lines_valid_q + LV_W'(1);
                end
            end
        end
    end

    // Read FSM: accept in IDLE, let the RAM settle in ADDR, present in CAP.
    // The line is registered on the ADDR->CAP edge so rd_valid appears two
    // cycles after acceptance; an invalid age walks the same path so both
    // outcomes share that latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q     <= RD_IDLE;
            rd_bad_q       <= 1'b0;
            ram_addr_out_q <= '0;
            rd_ready_q     <= 1'b1;
            rd_valid_q     <= 1'b0;
            rd_err_q       <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_req) begin
                        rd_ready_q <= 1'b0;
                        rd_state_q <= RD_ADDR;
                        rd_bad_q   <= ({1'b0, rd_age} >= lines_valid_q);
                        if ({1'b0, rd_age} < lines_valid_q) begin
                            ram_addr_out_q <= wr_ptr_q - ADDR_W'(1) - rd_age;
                        end
                    end
                end
                RD_ADDR: begin
                    rd_valid_q <= 1'b1;
                    rd_state_q <= RD_CAP;
                    if (rd_bad_q || hit_now || hit_next) begin
                        rd_err_q  <= 1'b1;
                        rd_data_q <= '0;
                    end else begin
                        rd_err_q  <= 1'b0;
                        rd_data_q <= ram_dout;
                    end
                end
                RD_CAP: begin
                    rd_ready_q <= 1'b1;
                    rd_state_q <= RD_IDLE;
                end
                default: begin
                    rd_ready_q <= 1'b1;
                    rd_state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign ram_we       = ram_we_q;
    assign ram_addr_in  = wr_ptr_q;
    assign ram_din      = ram_din_q;
    assign ram_addr_out = ram_addr_out_q;
    assign rd_ready     = rd_ready_q;
    assign rd_valid     = rd_valid_q;
    assign rd_err       = rd_err_q;
    assign rd_data      = rd_data_q;
    assign lines_valid  = lines_valid_q;

`ifdef BPM_HIST_AVG_EN
    localparam int ACC_W  = 12;
    localparam int NUM_W  = CNT_W + 1;
    localparam int STEP_W = $clog2(SAMPLE_W) + 1;

    logic [ACC_W-1:0]    acc_q, acc_sum, avg_sum_q;
    logic [NUM_W-1:0]    avg_cnt_q;
    logic                div_busy_q;
    logic [STEP_W-1:0]   div_step_q;
    logic [NUM_W-1:0]    div_rem_q, div_den_q, rem_nxt;
    logic [SAMPLE_W-1:0] div_num_q, div_quo_q;
    logic [NUM_W:0]      trial;
    logic                qbit;
    logic [SAMPLE_W-1:0] line_avg_q;
    logic                avg_valid_q;

    // Running line sum and one restoring-division step.
    // The sum is below 256*count, so its top bits are already smaller than
    // the divisor and SAMPLE_W steps yield the whole quotient.
    always_comb begin
        acc_sum = acc_q + (bpm_valid ? ACC_W'(bpm_in) : ACC_W'(0));
        trial   = {div_rem_q, div_num_q[SAMPLE_W-1]};
        qbit    = (trial >= {1'b0, div_den_q});
        rem_nxt = qbit ? NUM_W'(trial - {1'b0, div_den_q}) : NUM_W'(trial);
    end

    // Accumulate per line, then divide sum by sample count after each commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            avg_sum_q   <= '0;
            avg_cnt_q   <= '0;
            div_busy_q  <= 1'b0;
            div_step_q  <= '0;
            div_rem_q   <= '0;
            div_den_q   <= '0;
            div_num_q   <= '0;
            div_quo_q   <= '0;
            line_avg_q  <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            acc_q       <= line_done ? ACC_W'(0) : acc_sum;
            if (line_done) begin
                avg_sum_q <= acc_sum;
                avg_cnt_q <= NUM_W'(fill_cnt_q) + NUM_W'(bpm_valid);
            end
            if (ram_we_q) begin
                div_busy_q <= 1'b1;
                div_step_q <= '0;
                div_rem_q  <= NUM_W'(avg_sum_q[ACC_W-1:SAMPLE_W]);
                div_num_q  <= avg_sum_q[SAMPLE_W-1:0];
                div_den_q  <= avg_cnt_q;
                div_quo_q  <= '0;
            end else if (div_busy_q) begin
                div_rem_q  <= rem_nxt;
                div_num_q  <= {div_num_q[SAMPLE_W-2:0], 1'b0};
                div_quo_q  <= {div_quo_q[SAMPLE_W-2:0], qbit};
                div_step_q <= div_step_q + STEP_W'(1);
                if (div_step_q == STEP_W'(SAMPLE_W-1)) begin
                    div_busy_q  <= 1'b0;
                    avg_valid_q <= 1'b1;
                    line_avg_q  <= {div_quo_q[SAMPLE_W-2:0], qbit};
                end
            end
        end
    end

    assign line_avg  = line_avg_q;
    assign avg_valid = avg_valid_q;
`endif

endmodule
